// File: rtl/hms_timekeeper.sv
// ============================================================================
// Module      : hms_timekeeper
// Description : Single-clock HMS timekeeping core with tick divider, carry
//               chain and CLOCK/SETUP mode FSM driven by debounced switches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hms_timekeeper #(
    parameter int TICK_DIV = 50000000,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [5:0] o_hou,
    output logic       o_mode,
    output logic [1:0] o_position,
    output logic [2:0] o_sel,
    output logic       o_tick,
    output logic       o_day_pls
);

    localparam int              CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   C_TERM    = CW'(TICK_DIV - 1);
    localparam logic [5:0]      C_SEC_MAX = 6'(SEC_MAX);
    localparam logic [5:0]      C_MIN_MAX = 6'(MIN_MAX);
    localparam logic [5:0]      C_HOU_MAX = 6'(HOUR_MAX);
    localparam logic [1:0]      C_POS_SEC = 2'd0;
    localparam logic [1:0]      C_POS_MIN = 2'd1;
    localparam logic [1:0]      C_POS_HOU = 2'd2;

    typedef enum logic [0:0] {
        ST_CLOCK = 1'b0,
        ST_SETUP = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sw0_d;
    logic          r_sw1_d;
    logic          r_sw2_d;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [5:0]    r_hou;
    logic [1:0]    r_pos;
    logic          r_tick;
    logic          r_day_pls;

    logic          w_rise0;
    logic          w_rise1;
    logic          w_rise2;
    logic          w_tick;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    assign w_rise0 = i_sw0 & ~r_sw0_d;
    assign w_rise1 = i_sw1 & ~r_sw1_d;
    assign w_rise2 = i_sw2 & ~r_sw2_d;
    assign w_tick  = (r_cnt == C_TERM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_CLOCK;
            r_cnt     <= '0;
            r_sw0_d   <= 1'b0;
            r_sw1_d   <= 1'b0;
            r_sw2_d   <= 1'b0;
            r_sec     <= 6'd0;
            r_min     <= 6'd0;
            r_hou     <= 6'd0;
            r_pos     <= C_POS_SEC;
            r_tick    <= 1'b0;
            r_day_pls <= 1'b0;
        end else begin
            r_sw0_d   <= i_sw0;
            r_sw1_d   <= i_sw1;
            r_sw2_d   <= i_sw2;
            r_day_pls <= 1'b0;
            // A tick landing on a mode change is dropped entirely.
            r_tick    <= w_tick & ~w_rise0;

            if (w_rise0 || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_rise0) begin
                if (r_state == ST_CLOCK) begin
                    r_state <= ST_SETUP;
                    r_pos   <= C_POS_SEC;
                end else begin
                    r_state <= ST_CLOCK;
                end
            end else if (r_state == ST_CLOCK) begin
                if (w_tick) begin
                    if (r_sec == C_SEC_MAX) begin
                        r_sec <= 6'd0;
                        if (r_min == C_MIN_MAX) begin
                            r_min <= 6'd0;
                            if (r_hou == C_HOU_MAX) begin
                                r_hou     <= 6'd0;
                                r_day_pls <= 1'b1;
                            end else begin
                                r_hou <= r_hou + 6'd1;
                            end
                        end else begin
                            r_min <= r_min + 6'd1;
                        end
                    end else begin
                        r_sec <= r_sec + 6'd1;
                    end
                end
            end else begin
                // Increment targets the position held before any advance this cycle.
                if (w_rise2) begin
                    case (r_pos)
                        C_POS_SEC: r_sec <= inc_wrap(r_sec, C_SEC_MAX);
                        C_POS_MIN: r_min <= inc_wrap(r_min, C_MIN_MAX);
                        C_POS_HOU: r_hou <= inc_wrap(r_hou, C_HOU_MAX);
                        default:   r_sec <= r_sec;
                    endcase
                end
                if (w_rise1) begin
                    r_pos <= (r_pos == C_POS_HOU) ? C_POS_SEC : r_pos + 2'd1;
                end
            end
        end
    end

    always_comb begin
        o_sel = 3'b000;
        if (r_state == ST_SETUP) begin
            case (r_pos)
                C_POS_SEC: o_sel = 3'b001;
                C_POS_MIN: o_sel = 3'b010;
                C_POS_HOU: o_sel = 3'b100;
                default:   o_sel = 3'b000;
            endcase
        end
    end

    assign o_sec      = r_sec;
    assign o_min      = r_min;
    assign o_hou      = r_hou;
    assign o_mode     = (r_state == ST_SETUP);
    assign o_position = r_pos;
    assign o_tick     = r_tick;
    assign o_day_pls  = r_day_pls;

endmodule

`default_nettype wire

// File: tb/tb_hms_timekeeper.sv
// ============================================================================
// Module      : tb_hms_timekeeper
// Description : Directed self-checking bench for hms_timekeeper (TICK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hms_timekeeper;

    logic       clk;
    logic       rst_n;
    logic       sw0;
    logic       sw1;
    logic       sw2;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [5:0] o_hou;
    logic       o_mode;
    logic [1:0] o_position;
    logic [2:0] o_sel;
    logic       o_tick;
    logic       o_day_pls;

    int n_total;
    int n_pass;

    hms_timekeeper #(
        .TICK_DIV (4),
        .SEC_MAX  (59),
        .MIN_MAX  (59),
        .HOUR_MAX (23)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sw0      (sw0),
        .i_sw1      (sw1),
        .i_sw2      (sw2),
        .o_sec      (o_sec),
        .o_min      (o_min),
        .o_hou      (o_hou),
        .o_mode     (o_mode),
        .o_position (o_position),
        .o_sel      (o_sel),
        .o_tick     (o_tick),
        .o_day_pls  (o_day_pls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clean rise: high for one sampling edge, then low for one.
    task automatic press(input int which);
        if (which == 0) sw0 = 1'b1;
        if (which == 1) sw1 = 1'b1;
        if (which == 2) sw2 = 1'b1;
        step(1);
        sw0 = 1'b0;
        sw1 = 1'b0;
        sw2 = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sw0 = 1'b0;
        sw1 = 1'b0;
        sw2 = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw0 = 1'b0;
        sw1 = 1'b0;
        sw2 = 1'b0;
        step(3);
        n_total++;
        if ({o_hou, o_min, o_sec} !== 18'd0)
            $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", o_hou, o_min, o_sec);
        else n_pass++;
        n_total++;
        if ({o_mode, o_position, o_sel, o_tick, o_day_pls} !== 8'd0)
            $display("FAIL reset_ctrl: got mode=%0d pos=%0d sel=%b tick=%0d day=%0d want all 0",
                     o_mode, o_position, o_sel, o_tick, o_day_pls);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_clock_run();
        logic [11:0] pattern;
        pattern = '0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            pattern[k] = o_tick;
        end
        n_total++;
        if (pattern !== 12'b1000_1000_1000)
            $display("FAIL clock_tick_pattern: got %b want 100010001000", pattern);
        else n_pass++;
        n_total++;
        if ({o_hou, o_min, o_sec} !== {6'd0, 6'd0, 6'd3})
            $display("FAIL clock_time: got %0d:%0d:%0d want 0:0:3", o_hou, o_min, o_sec);
        else n_pass++;
    endtask

    task automatic test_day_wrap();
        do_reset();
        press(0);
        n_total++;
        if ({o_mode, o_position, o_sel} !== {1'b1, 2'd0, 3'b001})
            $display("FAIL enter_setup: got mode=%0d pos=%0d sel=%b want 1/0/001", o_mode, o_position, o_sel);
        else n_pass++;
        repeat (58) press(2);
        press(1);
        repeat (59) press(2);
        press(1);
        repeat (23) press(2);
        n_total++;
        if ({o_hou, o_min, o_sec, o_position, o_sel} !== {6'd23, 6'd59, 6'd58, 2'd2, 3'b100})
            $display("FAIL preload: got %0d:%0d:%0d pos=%0d sel=%b want 23:59:58 pos=2 sel=100",
                     o_hou, o_min, o_sec, o_position, o_sel);
        else n_pass++;
        press(0);
        step(2);
        n_total++;
        if ({o_mode, o_sel, o_hou, o_min, o_sec} !== {1'b0, 3'b000, 6'd23, 6'd59, 6'd58})
            $display("FAIL exit_setup: got mode=%0d sel=%b %0d:%0d:%0d want 0 000 23:59:58",
                     o_mode, o_sel, o_hou, o_min, o_sec);
        else n_pass++;
        step(1);
        n_total++;
        if ({o_tick, o_hou, o_min, o_sec} !== {1'b1, 6'd23, 6'd59, 6'd59})
            $display("FAIL first_tick: got tick=%0d %0d:%0d:%0d want 1 23:59:59", o_tick, o_hou, o_min, o_sec);
        else n_pass++;
        step(3);
        n_total++;
        if ({o_day_pls, o_hou, o_min, o_sec} !== {1'b0, 6'd23, 6'd59, 6'd59})
            $display("FAIL pre_wrap: got day=%0d %0d:%0d:%0d want 0 23:59:59", o_day_pls, o_hou, o_min, o_sec);
        else n_pass++;
        step(1);
        n_total++;
        if ({o_day_pls, o_hou, o_min, o_sec} !== {1'b1, 18'd0})
            $display("FAIL wrap: got day=%0d %0d:%0d:%0d want 1 0:0:0", o_day_pls, o_hou, o_min, o_sec);
        else n_pass++;
        step(1);
        n_total++;
        if (o_day_pls !== 1'b0)
            $display("FAIL day_pls_width: got %0d want 0", o_day_pls);
        else n_pass++;
    endtask

    task automatic test_setup_no_carry();
        do_reset();
        press(0);
        repeat (59) press(2);
        n_total++;
        if ({o_min, o_sec} !== {6'd0, 6'd59})
            $display("FAIL setup_sec59: got min=%0d sec=%0d want 0/59", o_min, o_sec);
        else n_pass++;
        sw2 = 1'b1;
        step(1);
        n_total++;
        if ({o_day_pls, o_hou, o_min, o_sec} !== {1'b0, 18'd0})
            $display("FAIL setup_wrap: got day=%0d %0d:%0d:%0d want 0 0:0:0", o_day_pls, o_hou, o_min, o_sec);
        else n_pass++;
        sw2 = 1'b0;
        step(1);
    endtask

    task automatic test_position_and_hold();
        press(1);
        n_total++;
        if ({o_position, o_sel} !== {2'd1, 3'b010})
            $display("FAIL pos_min: got pos=%0d sel=%b want 1/010", o_position, o_sel);
        else n_pass++;
        press(1);
        n_total++;
        if ({o_position, o_sel} !== {2'd2, 3'b100})
            $display("FAIL pos_hou: got pos=%0d sel=%b want 2/100", o_position, o_sel);
        else n_pass++;
        press(1);
        n_total++;
        if ({o_position, o_sel} !== {2'd0, 3'b001})
            $display("FAIL pos_sec: got pos=%0d sel=%b want 0/001", o_position, o_sel);
        else n_pass++;
        sw2 = 1'b1;
        step(20);
        sw2 = 1'b0;
        step(1);
        n_total++;
        if (o_sec !== 6'd1)
            $display("FAIL held_sw2: got sec=%0d want 1", o_sec);
        else n_pass++;
        sw1 = 1'b1;
        sw2 = 1'b1;
        step(1);
        sw1 = 1'b0;
        sw2 = 1'b0;
        n_total++;
        if ({o_position, o_min, o_sec} !== {2'd1, 6'd0, 6'd2})
            $display("FAIL sw1_sw2_together: got pos=%0d min=%0d sec=%0d want 1/0/2", o_position, o_min, o_sec);
        else n_pass++;
        step(1);
    endtask

    task automatic test_sw0_priority();
        do_reset();
        press(0);
        press(1);
        press(1);
        press(0);
        step(2);
        n_total++;
        if ({o_mode, o_sel, o_position, o_sec} !== {1'b0, 3'b000, 2'd2, 6'd0})
            $display("FAIL clock_before_toggle: got mode=%0d sel=%b pos=%0d sec=%0d want 0/000/2/0",
                     o_mode, o_sel, o_position, o_sec);
        else n_pass++;
        // This edge is also the tick counter's terminal count.
        sw0 = 1'b1;
        sw1 = 1'b1;
        step(1);
        sw0 = 1'b0;
        sw1 = 1'b0;
        n_total++;
        if ({o_mode, o_position, o_sel} !== {1'b1, 2'd0, 3'b001})
            $display("FAIL sw0_priority: got mode=%0d pos=%0d sel=%b want 1/0/001", o_mode, o_position, o_sel);
        else n_pass++;
        n_total++;
        if (o_sec !== 6'd0)
            $display("FAIL tick_discarded: got sec=%0d want 0", o_sec);
        else n_pass++;
        step(1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(0);
        repeat (56) press(2);
        press(1);
        repeat (34) press(2);
        press(1);
        repeat (12) press(2);
        n_total++;
        if ({o_mode, o_hou, o_min, o_sec} !== {1'b1, 6'd12, 6'd34, 6'd56})
            $display("FAIL preload_mid: got mode=%0d %0d:%0d:%0d want 1 12:34:56", o_mode, o_hou, o_min, o_sec);
        else n_pass++;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        n_total++;
        if ({o_hou, o_min, o_sec, o_mode, o_position, o_sel, o_tick, o_day_pls} !== 26'd0)
            $display("FAIL reset_mid: got %0d:%0d:%0d mode=%0d pos=%0d sel=%b tick=%0d day=%0d want all 0",
                     o_hou, o_min, o_sec, o_mode, o_position, o_sel, o_tick, o_day_pls);
        else n_pass++;
        step(3);
        n_total++;
        if (o_tick !== 1'b0)
            $display("FAIL restart_early: got tick=%0d want 0", o_tick);
        else n_pass++;
        step(1);
        n_total++;
        if ({o_tick, o_sec} !== {1'b1, 6'd1})
            $display("FAIL restart_tick: got tick=%0d sec=%0d want 1/1", o_tick, o_sec);
        else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0;
        sw0 = 1'b0;
        sw1 = 1'b0;
        sw2 = 1'b0;
        test_reset();
        test_clock_run();
        test_day_wrap();
        test_setup_no_carry();
        test_position_and_hold();
        test_sw0_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
